// File: rtl/wb_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// wb_arbiter_pkg
// Shared definitions for the operand-bank write arbiter: default word and
// address widths, the write-source select encoding, and the err bit indices.
// ----------------------------------------------------------------------------
package wb_arbiter_pkg;

    // Bank geometry and the redundant L3 polynomial word layout.
    localparam int BRAM_DEPTH         = 512;
    localparam int RED_POLY_L3_NCOEF  = 19;
    localparam int RED_POLY_L3_COEF_W = 16;

    localparam int DEF_DATA_W     = RED_POLY_L3_NCOEF * RED_POLY_L3_COEF_W;
    localparam int DEF_ADDR_W     = $clog2(BRAM_DEPTH);
    localparam int DEF_FIFO_DEPTH = 4;

    // Sticky error bit positions.
    localparam int ERR_INV_OVF  = 0;
    localparam int ERR_EXT_DROP = 1;

    // Owner of the bank write port in a given cycle.
    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_PIPE,
        SRC_FIFO,
        SRC_BYP,
        SRC_EXT
    } wr_src_t;

endpackage

// File: rtl/wb_arbiter_fifo.sv
// ----------------------------------------------------------------------------
// wb_fifo
// Synchronous FIFO for {addr, data} inverse results. Head is visible
// combinationally. A push while full is ignored unless a pop happens in the
// same cycle; a pop while empty is ignored.
//   clk, rst            clock, asynchronous active-high reset
//   i_push / i_data     write strobe and entry
//   i_pop               consume head
//   o_head              current head entry
//   o_level             occupancy 0..DEPTH
//   o_full / o_empty    status
// ----------------------------------------------------------------------------
module wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_level == LVL_W'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // NOTE: storage has no reset; the pointers and level define validity, and
    // leaving the array unreset lets it map onto plain distributed RAM.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers are exactly PTR_W bits, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_level = r_level;

endmodule

// File: rtl/wb_arbiter.sv
// ----------------------------------------------------------------------------
// wb_arbiter
// Write-port arbiter for the two operand BRAM banks. Three writers share the
// port: pipeline writeback (never stalls), modular-inverse results (buffered
// in a FIFO when they collide with the pipeline) and host loads (idle only).
//   clk, rst                         clock, asynchronous active-high reset
//   i_busy                           core running
//   i_ext_we/addr/data               host write
//   i_pipe_we0/we1/addr/data         pipeline writeback
//   i_inv_vld/addr/data              inverse result pulse
//   i_clr_err                        clear sticky errors
//   o_we0/o_we1/o_waddr/o_wdata      registered bank write port
//   o_inv_pending                    inverse result not yet written
//   o_fifo_level                     FIFO occupancy
//   o_err                            sticky [0] inverse overflow, [1] host drop
// ----------------------------------------------------------------------------
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_busy,
    input  logic                          i_ext_we,
    input  logic [ADDR_W-1:0]             i_ext_addr,
    input  logic [DATA_W-1:0]             i_ext_data,
    input  logic                          i_pipe_we0,
    input  logic                          i_pipe_we1,
    input  logic [ADDR_W-1:0]             i_pipe_addr,
    input  logic [DATA_W-1:0]             i_pipe_data,
    input  logic                          i_inv_vld,
    input  logic [ADDR_W-1:0]             i_inv_addr,
    input  logic [DATA_W-1:0]             i_inv_data,
    input  logic                          i_clr_err,
    output logic                          o_we0,
    output logic                          o_we1,
    output logic [ADDR_W-1:0]             o_waddr,
    output logic [DATA_W-1:0]             o_wdata,
    output logic                          o_inv_pending,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic [1:0]                    o_err
);

    logic                       w_fifo_full;
    logic                       w_fifo_empty;
    logic [ADDR_W+DATA_W-1:0]   w_fifo_head;
    logic                       w_push;
    logic                       w_pop;
    wr_src_t                    w_sel;
    logic [1:0]                 w_set_err;

    logic                       w_nxt_we0;
    logic                       w_nxt_we1;
    logic [ADDR_W-1:0]          w_nxt_addr;
    logic [DATA_W-1:0]          w_nxt_data;
    logic                       w_nxt_inv;

    logic                       r_we0;
    logic                       r_we1;
    logic [ADDR_W-1:0]          r_waddr;
    logic [DATA_W-1:0]          r_wdata;
    logic                       r_inv_out;
    logic [1:0]                 r_err;

    wb_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({i_inv_addr, i_inv_data}),
        .i_pop   (w_pop),
        .o_head  (w_fifo_head),
        .o_level (o_fifo_level),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Port ownership. Buffered results always go ahead of a fresh inverse
    // result, so bypass only happens with an empty FIFO and order holds.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_sel = SRC_NONE;
        if (i_busy) begin
            if (i_pipe_we0 || i_pipe_we1) w_sel = SRC_PIPE;
            else if (!w_fifo_empty)       w_sel = SRC_FIFO;
            else if (i_inv_vld)           w_sel = SRC_BYP;
        end else begin
            if (!w_fifo_empty)            w_sel = SRC_FIFO;
            else if (i_inv_vld)           w_sel = SRC_BYP;
            else if (i_ext_we)            w_sel = SRC_EXT;
        end
    end

    assign w_pop  = (w_sel == SRC_FIFO);
    assign w_push = i_inv_vld && (w_sel != SRC_BYP);

    always_comb begin
        w_set_err               = '0;
        w_set_err[ERR_INV_OVF]  = w_push && w_fifo_full && !w_pop;
        w_set_err[ERR_EXT_DROP] = !i_busy && i_ext_we &&
                                  ((w_sel == SRC_FIFO) || (w_sel == SRC_BYP));
    end

    always_comb begin
        w_nxt_we0  = 1'b0;
        w_nxt_we1  = 1'b0;
        w_nxt_addr = '0;
        w_nxt_data = '0;
        w_nxt_inv  = 1'b0;
        case (w_sel)
            SRC_PIPE: begin
                w_nxt_we0  = i_pipe_we0;
                w_nxt_we1  = i_pipe_we1;
                w_nxt_addr = i_pipe_addr;
                w_nxt_data = i_pipe_data;
            end
            SRC_FIFO: begin
                w_nxt_we0  = 1'b1;
                w_nxt_we1  = 1'b1;
                {w_nxt_addr, w_nxt_data} = w_fifo_head;
                w_nxt_inv  = 1'b1;
            end
            SRC_BYP: begin
                w_nxt_we0  = 1'b1;
                w_nxt_we1  = 1'b1;
                w_nxt_addr = i_inv_addr;
                w_nxt_data = i_inv_data;
                w_nxt_inv  = 1'b1;
            end
            SRC_EXT: begin
                w_nxt_we0  = 1'b1;
                w_nxt_we1  = 1'b1;
                w_nxt_addr = i_ext_addr;
                w_nxt_data = i_ext_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we0     <= 1'b0;
            r_we1     <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_inv_out <= 1'b0;
            r_err     <= '0;
        end else begin
            r_we0     <= w_nxt_we0;
            r_we1     <= w_nxt_we1;
            r_waddr   <= w_nxt_addr;
            r_wdata   <= w_nxt_data;
            r_inv_out <= w_nxt_inv;
            // A new error event in the clearing cycle survives the clear.
            r_err     <= (i_clr_err ? 2'b00 : r_err) | w_set_err;
        end
    end

    assign o_we0         = r_we0;
    assign o_we1         = r_we1;
    assign o_waddr       = r_waddr;
    assign o_wdata       = r_wdata;
    assign o_err         = r_err;
    assign o_inv_pending = (o_fifo_level != '0) || r_inv_out;

endmodule
